power_seq_ctrl: RTL

POWER_SEQ_CTRL -- requirements
Module: power_seq_ctrl

---
 rtl/power_seq_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/power_seq_ctrl.sv
// Power-domain sequencer: save -> isolate -> switch off, and the reverse on wake.
// Supervises pgood while the domain is powered and parks in ERROR on a loss.
module power_seq_ctrl #(
    parameter int SAVE_CYCLES    = 10,
    parameter int ISO_CYCLES     = 5,
    parameter int RESTORE_CYCLES = 10,
    parameter int PGOOD_TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_req,
    input  logic       wake_req,
    input  logic       pgood,
    input  logic       err_clr,
    output logic       save,
    output logic       restore,
    output logic       iso_en,
    output logic       pwr_sw_en,
    output logic       pd_ack,
    output logic       wake_ack,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ACTIVE      = 3'd0,
        SAVING      = 3'd1,
        ISOLATING   = 3'd2,
        OFF         = 3'd3,
        POWERING_ON = 3'd4,
        RESTORING   = 3'd5,
        ERROR       = 3'd6
    } state_t;

    localparam logic [15:0] SAVE_LAST    = 16'(SAVE_CYCLES - 1);
    localparam logic [15:0] ISO_LAST     = 16'(ISO_CYCLES - 1);
    localparam logic [15:0] RESTORE_LAST = 16'(RESTORE_CYCLES - 1);
    localparam logic [15:0] PGOOD_LAST   = 16'(PGOOD_TIMEOUT - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ACTIVE;
            cnt       <= '0;
            pd_ack    <= 1'b0;
            wake_ack  <= 1'b0;
        end else begin
            cur_state <= next_state;
            cnt       <= (next_state != cur_state) ? 16'd0 : cnt + 16'd1;
            // Acks mark only the completing transitions, so abort and ERROR->OFF stay silent.
            pd_ack    <= (cur_state == ISOLATING) && (next_state == OFF);
            wake_ack  <= (cur_state == RESTORING) && (next_state == ACTIVE);
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ACTIVE: begin
                if (!pgood)      next_state = ERROR;
                else if (pd_req) next_state = SAVING;
            end
            SAVING: begin
                // The last save cycle commits; a dropped request only aborts earlier.
                if (cnt == SAVE_LAST) next_state = ISOLATING;
                else if (!pd_req)     next_state = ACTIVE;
            end
            ISOLATING: begin
                if (cnt == ISO_LAST) next_state = OFF;
            end
            OFF: begin
                if (wake_req) next_state = POWERING_ON;
            end
            POWERING_ON: begin
                if (pgood)                  next_state = RESTORING;
                else if (cnt == PGOOD_LAST) next_state = ERROR;
            end
            RESTORING: begin
                if (!pgood)                   next_state = ERROR;
                else if (cnt == RESTORE_LAST) next_state = ACTIVE;
            end
            ERROR: begin
                if (err_clr) next_state = OFF;
            end
            default: next_state = ACTIVE;
        endcase
    end

    assign state     = cur_state;
    assign save      = (cur_state == SAVING);
    assign restore   = (cur_state == RESTORING);
    assign err       = (cur_state == ERROR);
    assign pwr_sw_en = (cur_state != OFF) && (cur_state != ERROR);
    assign iso_en    = (cur_state == ISOLATING) || (cur_state == OFF) ||
                       (cur_state == POWERING_ON) || (cur_state == RESTORING) ||
                       (cur_state == ERROR);

endmodule
